// File: rtl/pc_stack_unit_pkg.sv
// pc_stack_unit_pkg: widths, next-PC select codes and instruction field positions
package pc_stack_unit_pkg;
  localparam int ADDR_W = 12;
  localparam int INST_W = 19;
  localparam int STACK_DEPTH = 8;
  localparam int PTR_W = 3;
  localparam logic [1:0] NPC_INC = 2'b00;
  localparam logic [1:0] NPC_REL = 2'b01;
  localparam logic [1:0] NPC_ABS = 2'b10;
  localparam logic [1:0] NPC_HOLD = 2'b11;
  localparam int ADDR_MSB = 11;
  localparam int ADDR_LSB = 0;
  localparam int OFF_MSB = 7;
  localparam int OFF_LSB = 0;
  function automatic logic [ADDR_W-1:0] sextOff(input logic [OFF_MSB-OFF_LSB:0] off);
    return {{(ADDR_W-OFF_MSB+OFF_LSB-1){off[OFF_MSB-OFF_LSB]}}, off};
  endfunction
endpackage

// File: rtl/pc_stack_unit_if.sv
// pc_stack_unit_if: controller-to-PC-stage control bus and status outputs
interface pc_stack_unit_if;
  import pc_stack_unit_pkg::*;
  logic [INST_W-1:0] allBits;
  logic enablePC;
  logic [1:0] selectAdress;
  logic push;
  logic RET;
  logic [ADDR_W-1:0] inst_addr;
  logic [PTR_W:0] sp;
  logic stack_empty;
  logic stack_full;
  logic stack_overflow;
  logic stack_underflow;
  logic stack_conflict;
  modport master (
    output allBits, enablePC, selectAdress, push, RET,
    input inst_addr, sp, stack_empty, stack_full, stack_overflow, stack_underflow, stack_conflict
  );
  modport slave (
    input allBits, enablePC, selectAdress, push, RET,
    output inst_addr, sp, stack_empty, stack_full, stack_overflow, stack_underflow, stack_conflict
  );
endinterface

// File: rtl/pc_stack_unit_return_stack.sv
// return_stack: LIFO of return addresses; pointer resets, storage does not
module return_stack
  import pc_stack_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic [PTR_W:0] sp,
  output logic full,
  output logic empty
);
  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [PTR_W:0] spPrev;
  assign spPrev = sp - 1'b1;
  assign top = mem[spPrev[PTR_W-1:0]];
  assign full = sp == (PTR_W+1)'(STACK_DEPTH);
  assign empty = sp == '0;
  // occupancy moves up on an accepted push, down on an accepted pop
  always_ff @(posedge clk or posedge rst)
    if (rst) sp <= '0;
    else sp <= push && !full ? sp + 1'b1 : pop && !empty ? spPrev : sp;
  // write the saved address into the next free slot
  always_ff @(posedge clk)
    if (push && !full) mem[sp[PTR_W-1:0]] <= din;
endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: PC register, next-PC priority mux, call/return stack and sticky error flags
module pc_stack_unit
  import pc_stack_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  pc_stack_unit_if.slave bus
);
  logic [ADDR_W-1:0] pc, pcInc, pcRel, target, selPc, nextPc, top;
  logic [PTR_W:0] sp;
  logic full, empty, en, both, onlyRet, onlyPush;
  logic overflow, underflow, conflict;
  assign en = bus.enablePC;
  assign both = en && bus.push && bus.RET;
  assign onlyRet = en && bus.RET && !bus.push;
  assign onlyPush = en && bus.push && !bus.RET;
  return_stack stack (
    .clk(clk), .rst(rst), .push(onlyPush), .pop(onlyRet), .din(pcInc),
    .top(top), .sp(sp), .full(full), .empty(empty)
  );
  // next PC: conflict beats return beats call beats the select field
  always_comb begin
    pcInc = pc + 1'b1;
    target = bus.allBits[ADDR_MSB:ADDR_LSB];
    pcRel = pcInc + sextOff(bus.allBits[OFF_MSB:OFF_LSB]);
    selPc = bus.selectAdress == NPC_INC ? pcInc :
            bus.selectAdress == NPC_REL ? pcRel :
            bus.selectAdress == NPC_ABS ? target : pc;
    nextPc = !en ? pc : both ? pcInc : onlyRet ? (empty ? pcInc : top) : onlyPush ? target : selPc;
  end
  // PC register
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= '0;
    else pc <= nextPc;
  // sticky error flags, cleared only by reset
  always_ff @(posedge clk or posedge rst)
    if (rst) {overflow, underflow, conflict} <= '0;
    else begin
      overflow <= overflow | (onlyPush && full);
      underflow <= underflow | (onlyRet && empty);
      conflict <= conflict | both;
    end
  assign bus.inst_addr = pc;
  assign bus.sp = sp;
  assign bus.stack_empty = empty;
  assign bus.stack_full = full;
  assign bus.stack_overflow = overflow;
  assign bus.stack_underflow = underflow;
  assign bus.stack_conflict = conflict;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed and random stimulus against a queue-based reference model
module tb_pc_stack_unit;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  logic [11:0] mPc = 0;
  logic [11:0] mStack[$];
  logic mOvf = 0, mUnd = 0, mCon = 0;
  logic [11:0] saved[$];
  pc_stack_unit_if bus();
  pc_stack_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chkAll(input string tag);
    chk({tag, ".pc"}, int'(bus.inst_addr), int'(mPc));
    chk({tag, ".sp"}, int'(bus.sp), mStack.size());
    chk({tag, ".empty"}, int'(bus.stack_empty), int'(mStack.size() == 0));
    chk({tag, ".full"}, int'(bus.stack_full), int'(mStack.size() == 8));
    chk({tag, ".ovf"}, int'(bus.stack_overflow), int'(mOvf));
    chk({tag, ".und"}, int'(bus.stack_underflow), int'(mUnd));
    chk({tag, ".con"}, int'(bus.stack_conflict), int'(mCon));
  endtask

  task automatic modelReset();
    mPc = 0;
    mStack.delete();
    {mOvf, mUnd, mCon} = 3'b000;
  endtask

  task automatic step(input string tag, input logic en, input logic [1:0] sel,
                      input logic pu, input logic re, input logic [18:0] bits);
    logic [11:0] off;
    bus.enablePC = en;
    bus.selectAdress = sel;
    bus.push = pu;
    bus.RET = re;
    bus.allBits = bits;
    @(posedge clk);
    off = {{4{bits[7]}}, bits[7:0]};
    if (en) begin
      if (pu && re) begin
        mPc = mPc + 1;
        mCon = 1;
      end else if (re) begin
        if (mStack.size() > 0) mPc = mStack.pop_back();
        else begin
          mPc = mPc + 1;
          mUnd = 1;
        end
      end else if (pu) begin
        if (mStack.size() < 8) mStack.push_back(mPc + 12'd1);
        else mOvf = 1;
        mPc = bits[11:0];
      end else if (sel == 2'b00) mPc = mPc + 1;
      else if (sel == 2'b01) mPc = mPc + 12'd1 + off;
      else if (sel == 2'b10) mPc = bits[11:0];
    end
    #1 chkAll(tag);
  endtask

  initial begin
    bus.enablePC = 0;
    bus.selectAdress = 0;
    bus.push = 0;
    bus.RET = 0;
    bus.allBits = 0;
    #12 rst = 0;
    modelReset();
    chkAll("reset");
    step("und0", 1, 2'b00, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("pre_push", 1, 2'b00, 1, 0, 19'(12'h100 + i));
    step("pre_abs", 1, 2'b10, 0, 0, 19'h002A5);
    chk("pre_pc", int'(bus.inst_addr), 12'h2A5);
    chk("pre_sp", int'(bus.sp), 3);
    #2 rst = 1;
    modelReset();
    #1 chk("async_pc", int'(bus.inst_addr), 0);
    chk("async_sp", int'(bus.sp), 0);
    chkAll("async");
    @(negedge clk) rst = 0;
    for (int i = 0; i < 4; i++) begin
      step("inc", 1, 2'b00, 0, 0, 0);
      chk("inc_lit", int'(bus.inst_addr), i + 1);
    end
    step("rel_back", 1, 2'b01, 0, 0, 19'h000FE);
    chk("rel_lit", int'(bus.inst_addr), 3);
    step("abs_fff", 1, 2'b10, 0, 0, 19'h00FFF);
    step("wrap", 1, 2'b00, 0, 0, 0);
    chk("wrap_lit", int'(bus.inst_addr), 0);
    step("rel_wrap", 1, 2'b01, 0, 0, 19'h00080);
    step("hold", 1, 2'b11, 0, 0, 0);
    step("abs_010", 1, 2'b10, 0, 0, 19'h00010);
    step("call", 1, 2'b00, 1, 0, 19'h7F100);
    chk("call_lit", int'(bus.inst_addr), 12'h100);
    step("ret", 1, 2'b00, 0, 1, 0);
    chk("ret_lit", int'(bus.inst_addr), 12'h011);
    saved.delete();
    for (int i = 0; i < 9; i++) begin
      logic [18:0] b;
      b = 19'($urandom);
      if (i < 8) saved.push_back(mPc + 12'd1);
      step("push9", 1, 2'($urandom), 1, 0, b);
      chk("push9_jump", int'(bus.inst_addr), int'(b[11:0]));
    end
    chk("ovf_lit", int'(bus.stack_overflow), 1);
    for (int i = 0; i < 8; i++) begin
      step("ret8", 1, 2'($urandom), 0, 1, 19'($urandom));
      chk("ret8_lit", int'(bus.inst_addr), int'(saved.pop_back()));
    end
    step("ret9", 1, 2'b10, 0, 1, 19'h00ABC);
    chk("und_lit", int'(bus.stack_underflow), 1);
    step("abs_050", 1, 2'b10, 0, 0, 19'h00050);
    step("push_first", 1, 2'b00, 1, 0, 19'h00200);
    step("conflict", 1, 2'b10, 1, 1, 19'h00333);
    chk("con_lit", int'(bus.stack_conflict), 1);
    step("disabled", 0, 2'b10, 1, 0, 19'h00444);
    step("disabled_ret", 0, 2'b01, 0, 1, 19'h000FF);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 1;
        modelReset();
        #1 chkAll("rnd_rst");
        @(negedge clk) rst = 0;
      end
      step("rnd", $urandom_range(0, 4) != 0, 2'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, 19'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
